// File: rtl/jt51_wrseq.sv
// Queues host register writes and plays them into a YM2151 as address/data strobe pairs,
// skipping the address write when the register is unchanged and waiting out the busy flag.
module jt51_wrseq #(
  parameter int AW   = 2,
  parameter int TOUT = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_addr,
  input  logic [7:0]    cmd_data,
  output logic [7:0]    dout,
  output logic          a0,
  output logic          write,
  input  logic          busy,
  output logic          idle,
  output logic          timeout,
  output logic [AW:0]   fifo_cnt
);

  // state | meaning
  // IDLE  | waiting for a queued command      ADDR | address strobe
  // GAP   | write low between strobes         DATA | data strobe
  // HOLD  | covers busy-set latency           WAIT | poll busy, bounded by TOUT
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  localparam int DEPTH = 1 << AW;
  localparam int TW    = (TOUT < 1) ? 1 : $clog2(TOUT + 1);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [2:0]    state_q, state_d;
  logic [15:0]   cur_q;
  logic [7:0]    last_addr_q;
  logic          last_valid_q;
  logic [TW-1:0] tcnt_q;
  logic          timeout_q;
  logic          push, pop, tout_hit;
  logic [15:0]   head;

  assign cmd_ready = (cnt_q != (AW+1)'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign tout_hit  = (tcnt_q == TW'(TOUT));
  assign fifo_cnt  = cnt_q;
  assign timeout   = timeout_q;
  assign idle      = (state_q == S_IDLE) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop) state_d = (last_valid_q && head[15:8] == last_addr_q) ? S_DATA : S_ADDR;
      S_ADDR: state_d = S_GAP;
      S_GAP:  state_d = S_DATA;
      S_DATA: state_d = S_HOLD;
      S_HOLD: state_d = S_WAIT;
      S_WAIT: if (!busy || tout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe outputs are registered from the current state, so they trail the FSM by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      tcnt_q       <= '0;
      timeout_q    <= 1'b0;
      write        <= 1'b0;
      a0           <= 1'b0;
      dout         <= 8'h00;
    end else begin
      state_q <= state_d;
      if (pop) cur_q <= head;
      if (state_q == S_ADDR) begin
        last_addr_q  <= cur_q[15:8];
        last_valid_q <= 1'b1;
      end
      if (state_q == S_HOLD) tcnt_q <= '0;
      else if (state_q == S_WAIT && cen && !tout_hit) tcnt_q <= tcnt_q + 1'b1;
      if (state_q == S_WAIT && busy && tout_hit) timeout_q <= 1'b1;
      write <= (state_q == S_ADDR) || (state_q == S_DATA);
      if (state_q == S_ADDR) begin
        a0   <= 1'b0;
        dout <= cur_q[15:8];
      end else if (state_q == S_DATA) begin
        a0   <= 1'b1;
        dout <= cur_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_jt51_wrseq.sv
// Scoreboard bench for jt51_wrseq: every push queues the strobes it should produce,
// and a negedge monitor pops and compares them as the DUT emits write pulses.
module tb_jt51_wrseq;
  localparam int AW = 2;
  localparam int TOUT = 63;
  localparam int DEPTH = 4;

  logic clk = 0, rst_n = 0, cen = 0, cmd_valid = 0, busy = 0;
  logic [7:0] cmd_addr = 0, cmd_data = 0;
  logic cmd_ready, a0, write, idle, timeout;
  logic [7:0] dout;
  logic [AW:0] fifo_cnt;

  int checks = 0, fails = 0;
  logic [8:0] sb[$];
  int strobe_cycs[$];
  int cyc = 0, acc_cyc = 0;
  bit busy_auto = 0, chk_idle = 0, fell = 0;
  int busy_ticks = 32, busy_left = 0;
  int tick_phase = 0, wt = 0, to_ticks = -1;
  logic prev_to = 0, prev_write = 0;
  logic [7:0] m_last = 0;
  bit m_valid = 0;

  jt51_wrseq #(.AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .dout(dout), .a0(a0), .write(write), .busy(busy),
    .idle(idle), .timeout(timeout), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor, cen generator and chip busy model share one negedge process to avoid races.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (tick_phase == 1) tick_phase = 2;
      else if (tick_phase == 2 && cen) wt++;
      if (timeout && !prev_to) to_ticks = wt;
      prev_to = timeout;
      if (fell) begin
        if (chk_idle) check("idle_after_busy", 16'(idle), 16'd1);
        fell = 0;
      end
      if (rst_n) begin
        check("ready_vs_cnt", 16'(cmd_ready), 16'(fifo_cnt != (AW+1)'(DEPTH)));
        if (write) begin
          check("strobe_gap", 16'(prev_write), 16'd0);
          if (sb.size() == 0) check("sb_underflow", 16'(sb.size()), 16'd1);
          else begin
            e = sb.pop_front();
            check("strobe", 16'({a0, dout}), 16'(e));
          end
          strobe_cycs.push_back(cyc);
          if (a0) begin
            tick_phase = 1;
            wt = 0;
          end
        end
      end
      if (busy_auto) begin
        if (write && a0) begin
          busy = 1;
          busy_left = busy_ticks;
        end else if (busy && cen) begin
          busy_left--;
          if (busy_left <= 0) begin
            busy = 0;
            fell = 1;
            if (chk_idle) check("idle_before_fall", 16'(idle), 16'd0);
          end
        end
      end
      prev_write = write;
      cen = ~cen;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_addr = a;
    cmd_data = d;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("push_wait", 16'(cmd_ready), 16'd1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 0;
    if (!(m_valid && m_last == a)) begin
      sb.push_back({1'b0, a});
      m_last = a;
      m_valid = 1;
    end
    sb.push_back({1'b1, d});
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(idle && sb.size() == 0 && !busy) && n < 3000);
    check("drain", 16'(idle && sb.size() == 0), 16'd1);
  endtask

  initial begin
    int n0, a, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", 16'(write), 16'd0);
    check("rst_a0", 16'(a0), 16'd0);
    check("rst_dout", 16'(dout), 16'd0);
    check("rst_cnt", 16'(fifo_cnt), 16'd0);
    check("rst_ready", 16'(cmd_ready), 16'd1);
    check("rst_idle", 16'(idle), 16'd1);
    check("rst_timeout", 16'(timeout), 16'd0);
    @(negedge clk) rst_n = 1;

    // single write with 32-tick busy
    busy_auto = 1; busy_ticks = 32; chk_idle = 1;
    n0 = strobe_cycs.size();
    push(8'h20, 8'hC7);
    a = acc_cyc;
    wait_drain();
    chk_idle = 0;
    check("single_strobes", 16'(strobe_cycs.size() - n0), 16'd2);
    if (strobe_cycs.size() >= n0 + 2) begin
      check("first_write_lat", 16'(strobe_cycs[n0] - a), 16'd2);
      check("strobe_spacing", 16'(strobe_cycs[n0+1] - strobe_cycs[n0]), 16'd2);
    end

    // address skip
    busy_ticks = 4;
    n0 = strobe_cycs.size();
    push(8'h08, 8'h78);
    push(8'h08, 8'h00);
    wait_drain();
    check("skip_strobes", 16'(strobe_cycs.size() - n0), 16'd3);

    // simultaneous push and pop at fifo_cnt=2
    busy_auto = 0; busy = 1;
    push(8'h50, 8'h11);
    push(8'h51, 8'h22);
    push(8'h52, 8'h33);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre_simul_cnt", 16'(fifo_cnt), 16'd2);
    busy = 0;
    push(8'h53, 8'h44);
    check("simul_cnt", 16'(fifo_cnt), 16'd2);
    wait_drain();

    // timeout with busy stuck high
    check("timeout_clear", 16'(timeout), 16'd0);
    busy = 1;
    push(8'h14, 8'h15);
    n = 0;
    while (!timeout && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_flag", 16'(timeout), 16'd1);
    check("idle_after_to", 16'(idle), 16'd1);
    @(negedge clk);
    #1;
    check("timeout_ticks", 16'(to_ticks), 16'(TOUT));
    busy = 0;
    push(8'h14, 8'h33);
    wait_drain();
    check("timeout_sticky", 16'(timeout), 16'd1);

    // FIFO full with busy held
    busy = 1;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 8'hA0 + 8'(i));
    @(negedge clk);
    #1;
    check("full_cnt", 16'(fifo_cnt), 16'd4);
    check("full_ready", 16'(cmd_ready), 16'd0);
    push(8'h45, 8'hA5);
    busy = 0;
    wait_drain();

    // reset asserted in DATA
    push(8'h30, 8'h01);
    push(8'h31, 8'h02);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("rstdata_write", 16'(write), 16'd0);
    check("rstdata_cnt", 16'(fifo_cnt), 16'd0);
    check("rstdata_idle", 16'(idle), 16'd1);
    check("rstdata_timeout", 16'(timeout), 16'd0);
    sb.delete();
    m_valid = 0;
    @(negedge clk) rst_n = 1;
    n0 = strobe_cycs.size();
    push(8'h31, 8'h55);
    wait_drain();
    check("post_rst_strobes", 16'(strobe_cycs.size() - n0), 16'd2);

    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/jt51_wrseq.md
JT51_WRSEQ -- requirements
Module: jt51_wrseq

Interface
REQ-001 SHALL have parameter AW, default 2, giving log2 of the command FIFO depth (4 entries).
REQ-002 SHALL have parameter TOUT, default 63, giving the maximum busy wait in cen ticks before the wait is abandoned.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cen, input, 1 bit: synth clock enable (P1), the same enable that drives the YM2151 core.
REQ-006 SHALL have port cmd_valid, input, 1 bit: host offers a register write.
REQ-007 SHALL have port cmd_ready, output, 1 bit: FIFO can accept a command; equals not-full.
REQ-008 SHALL have port cmd_addr, input, 8 bits: YM2151 register number.
REQ-009 SHALL have port cmd_data, input, 8 bits: value to write.
REQ-010 SHALL have port dout, output, 8 bits: bus to the chip's din.
REQ-011 SHALL have port a0, output, 1 bit: 0 selects an address write, 1 selects a data write.
REQ-012 SHALL have port write, output, 1 bit: write strobe to the chip.
REQ-013 SHALL have port busy, input, 1 bit: chip busy flag.
REQ-014 SHALL have port idle, output, 1 bit: high when the FSM is in IDLE and the FIFO is empty.
REQ-015 SHALL have port timeout, output, 1 bit: sticky flag, set when a busy wait expires.
REQ-016 SHALL have port fifo_cnt, output, AW+1 bits: current FIFO occupancy.

Function
REQ-017 SHALL push {cmd_addr, cmd_data} on each rising clk edge where cmd_valid and cmd_ready are both high; a push SHALL NOT depend on cen.
REQ-018 SHALL, when a push and a pop occur on the same edge, leave fifo_cnt unchanged and lose no data; a push while full SHALL be impossible because cmd_ready is low.
REQ-019 SHALL wrap the FIFO read and write pointers modulo 2^AW and deliver commands in FIFO order.
REQ-020 SHALL implement FSM states IDLE, ADDR, GAP, DATA, HOLD and WAIT.
REQ-021 SHALL, in IDLE with the FIFO not empty, pop the head entry into the current-command register on that edge.
REQ-022 SHALL, on that same IDLE pop edge, enter DATA when last_valid is set and cmd_addr equals last_addr (address-write skip), and enter ADDR otherwise.
REQ-023 SHALL, in ADDR, drive write=1, a0=0, dout=addr for exactly one clk, then set last_addr=addr and last_valid=1, and go to GAP.
REQ-024 SHALL, in GAP, drive write=0 for exactly one clk, so every write strobe has a rising edge, then go to DATA.
REQ-025 SHALL, in DATA, drive write=1, a0=1, dout=data for exactly one clk, then go to HOLD.
REQ-026 SHALL, in HOLD, drive write=0 for one clk and ignore busy, which covers the chip's one-cycle busy-set latency, then go to WAIT.
REQ-027 SHALL, in WAIT, remain while busy=1 and count cen ticks in a saturating counter cleared on entry to WAIT.
REQ-028 SHALL, in WAIT, go to IDLE on the first clk where busy=0.
REQ-029 SHALL, in WAIT, set timeout=1 and go to IDLE when the counter reaches TOUT with busy still high.
REQ-030 SHALL drive write, a0 and dout from registers only, with no combinational path from any input.
REQ-031 SHALL hold dout and a0 at their last values and write=0 in every state except ADDR and DATA.
REQ-032 SHALL assert write for the first time two clk edges after the accepting edge when the FIFO was empty and the FSM was in IDLE.
REQ-033 SHALL, when the busy wait was abandoned (timeout), still leave last_addr valid.
REQ-034 SHALL clear the timeout flag only by reset.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously force state=IDLE, write=0, a0=0, dout=0x00, FIFO empty (fifo_cnt=0, cmd_ready=1), last_valid=0, timeout=0, idle=1.
REQ-036 SHALL, on reset asserted mid-sequence (any state), abandon the current and all queued commands, and the first command after reset SHALL always perform an ADDR phase.

Verification
REQ-037 SHALL cover a single write: push (0x20,0xC7); busy high for 32 cen ticks -> write pulses with a0=0/dout=0x20, then a0=1/dout=0xC7, one clk each, separated by one write=0 clk; idle returns one clk after busy falls.
REQ-038 SHALL cover the address skip: push (0x08,0x78) then (0x08,0x00) -> the second command produces only a data strobe (a0=1, dout=0x00), with no a0=0 strobe.
REQ-039 SHALL cover FIFO full: hold busy=1 and push 6 commands back-to-back -> cmd_ready drops when fifo_cnt=4, and all accepted commands come out in order with no loss.
REQ-040 SHALL cover the timeout: push (0x14,0x15) and hold busy=1 permanently -> timeout=1 after 63 cen ticks in WAIT, and the FSM returns to IDLE and serves the next command.
REQ-041 SHALL cover reset in DATA: assert rst_n=0 in the DATA state -> write=0 and fifo_cnt=0 immediately, and the next command after release starts with an a0=0 strobe.
REQ-042 SHALL cover a simultaneous push and pop at fifo_cnt=2 -> fifo_cnt stays 2 and the data order is preserved.
